// File: rtl/tlul_pkg.sv
// TL-UL opcodes and the host/device channel bundles shared by TL-UL endpoints.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_bridge_pkg.sv
// Response-entry type, occupancy width and byte-mask helper for the TL-UL to SRAM bridge.
package tlul_sram_bridge_pkg;

    localparam int unsigned MaxDepth = 16;
    localparam int unsigned CntW     = $clog2(MaxDepth + 1);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [7:0]  source;
        logic [1:0]  size;
        logic        error;
        logic [31:0] data;
    } rsp_entry_t;

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            w[8*b +: 8] = {8{m[b]}};
        end
        return w;
    endfunction

endpackage

// File: rtl/tlul_bridge_rsp_fifo.sv
// Circular response buffer with occupancy count; synchronous active-low reset.
module tlul_bridge_rsp_fifo
    import tlul_sram_bridge_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = rsp_entry_t
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  entry_t          push_data_i,
    input  logic            pop_i,
    output logic            valid_o,
    output entry_t          head_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned     PtrW    = $clog2(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tlul_sram_bridge.sv
// TL-UL device adapter onto a 1-cycle-latency SRAM; responses are returned in order
// through a small FIFO whose occupancy gates a_ready.
module tlul_sram_bridge
    import tlul_pkg::*;
    import tlul_sram_bridge_pkg::*;
#(
    parameter int unsigned AW    = 12,
    parameter int unsigned Depth = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic [31:0]   wmask_o,
    input  logic [31:0]   rdata_i
);

    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    logic            a_ready, accept, err;
    logic [3:0]      full_mask;
    logic            bad_op, bad_size, misalign, bad_mask, bad_range;
    logic            pend_q, pend_rd_q, pend_rd_d;
    rsp_entry_t      pend_rsp_q, pend_rsp_d, push_entry, head;
    logic            fifo_valid, d_valid, pop;
    logic [CntW-1:0] fifo_count;

    always_comb begin
        case (tl_i.a_size)
            2'd0:    full_mask = 4'b0001 << tl_i.a_address[1:0];
            2'd1:    full_mask = 4'b0011 << {tl_i.a_address[1], 1'b0};
            default: full_mask = 4'b1111;
        endcase
        bad_op    = !(tl_i.a_opcode inside {PutFullData, PutPartialData, Get});
        bad_size  = (tl_i.a_size == 2'd3);
        misalign  = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                    ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));
        bad_mask  = (tl_i.a_opcode == PutFullData) && (tl_i.a_mask != full_mask);
        bad_range = ((tl_i.a_address >> (AW + 2)) != 32'h0);
        err       = bad_op | bad_size | misalign | bad_mask | bad_range;
    end

    // Occupancy counts the beat accepted last cycle that has not reached the FIFO yet.
    assign a_ready = rst_ni && ((fifo_count + CntW'(pend_q)) < DepthC);
    assign accept  = tl_i.a_valid && a_ready;

    assign req_o   = accept && !err;
    assign we_o    = req_o && (tl_i.a_opcode != Get);
    assign addr_o  = tl_i.a_address[AW+1:2];
    assign wdata_o = tl_i.a_data;
    assign wmask_o = expand_mask(tl_i.a_mask);

    always_comb begin
        pend_rsp_d        = '0;
        pend_rsp_d.opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
        pend_rsp_d.source = tl_i.a_source;
        pend_rsp_d.size   = tl_i.a_size;
        pend_rsp_d.error  = err;
        pend_rd_d         = accept && !err && (tl_i.a_opcode == Get);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q     <= 1'b0;
            pend_rd_q  <= 1'b0;
            pend_rsp_q <= '0;
        end else begin
            pend_q     <= accept;
            pend_rd_q  <= pend_rd_d;
            pend_rsp_q <= pend_rsp_d;
        end
    end

    always_comb begin
        push_entry      = pend_rsp_q;
        push_entry.data = pend_rd_q ? rdata_i : 32'h0;
    end

    tlul_bridge_rsp_fifo #(
        .Depth   (Depth),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (pend_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign d_valid = rst_ni && fifo_valid;
    assign pop     = d_valid && tl_i.d_ready;

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = head.opcode;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_data   = head.data;
            tl_o.d_error  = head.error;
        end
    end

endmodule

// File: tb/tb_tlul_sram_bridge.sv
// Randomised scoreboard bench for tlul_sram_bridge with an SRAM stub and word-level memory model.
module tb_tlul_sram_bridge;
    import tlul_pkg::*;
    import tlul_sram_bridge_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned Depth = 4;
    localparam int unsigned Words = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_valid;
    logic [2:0]    a_opcode;
    logic [1:0]    a_size;
    logic [7:0]    a_source;
    logic [31:0]   a_address;
    logic [3:0]    a_mask;
    logic [31:0]   a_data;
    logic          d_ready;
    tl_h2d_t       tl_i;
    tl_d2h_t       tl_o;
    logic          req, we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, wmask, rdata;

    assign tl_i = '{a_valid: a_valid, a_opcode: a_opcode, a_size: a_size, a_source: a_source,
                    a_address: a_address, a_mask: a_mask, a_data: a_data, d_ready: d_ready};

    tlul_sram_bridge #(
        .AW    (AW),
        .Depth (Depth)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .req_o   (req),
        .we_o    (we),
        .addr_o  (addr),
        .wdata_o (wdata),
        .wmask_o (wmask),
        .rdata_i (rdata)
    );

    // SRAM stub: byte-masked write, read data one cycle after the request.
    logic [31:0] sram [Words];
    initial begin
        for (int i = 0; i < int'(Words); i++) sram[i] = 32'h0;
        rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (req && we) sram[addr] <= (sram[addr] & ~wmask) | (wdata & wmask);
            if (req && !we) rdata <= sram[addr];
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          dr_mode = 0;
    int          acc_cyc = 0;
    int          first_dv_cyc = -1;
    bit          dv_arm = 0;
    logic [7:0]  src_ctr = 8'd0;
    bit   [31:0] ref_mem [Words];
    rsp_entry_t  exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        d_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (dr_mode)
                0:       d_ready = 1'b1;
                1:       d_ready = 1'($urandom_range(0, 1));
                default: d_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (tl_o !== '0 || req !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got tl_o=%h req=%b, expected all zero", tl_o, req);
            end
        end else if (tl_o.d_valid) begin
            if (dv_arm) begin
                first_dv_cyc = cyc;
                dv_arm = 0;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got op=%0d src=%0d data=%h, expected no response",
                         tl_o.d_opcode, tl_o.d_source, tl_o.d_data);
            end else begin
                if (tl_o.d_opcode !== exp_q[0].opcode || tl_o.d_source !== exp_q[0].source ||
                    tl_o.d_size !== exp_q[0].size || tl_o.d_error !== exp_q[0].error ||
                    tl_o.d_data !== exp_q[0].data || tl_o.d_param !== 3'd0 ||
                    tl_o.d_sink !== 1'b0 || tl_o.d_user !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp: got op=%0d src=%0d sz=%0d err=%0d data=%h, expected op=%0d src=%0d sz=%0d err=%0d data=%h",
                             tl_o.d_opcode, tl_o.d_source, tl_o.d_size, tl_o.d_error, tl_o.d_data,
                             exp_q[0].opcode, exp_q[0].source, exp_q[0].size, exp_q[0].error,
                             exp_q[0].data);
                end
                if (d_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model of one accepted beat: checks the SRAM command and queues the response.
    task automatic on_accept();
        int          sz = int'(a_size);
        int          off = int'(a_address[1:0]);
        int          fm;
        bit          bad;
        bit          ok;
        logic [31:0] wm;
        logic [AW-1:0] w;
        rsp_entry_t  e;
        fm  = ((1 << (1 << sz)) - 1) << off;
        bad = !(a_opcode inside {3'd0, 3'd1, 3'd4}) || (sz > 2) ||
              ((a_address % (32'd1 << sz)) != 0) ||
              (longint'(a_address) >= (longint'(1) << (AW + 2))) ||
              (a_opcode == 3'd0 && sz <= 2 && int'(a_mask) != fm);
        for (int b = 0; b < 4; b++) wm[8*b +: 8] = a_mask[b] ? 8'hff : 8'h00;
        w = AW'(a_address >> 2);
        checks++;
        if (bad) ok = (req === 1'b0);
        else ok = (req === 1'b1) && (we === (a_opcode != 3'd4)) && (addr === w) &&
                  (a_opcode == 3'd4 || (wdata === a_data && wmask === wm));
        if (!ok) begin
            errors++;
            $display("FAIL sram_cmd: got req=%b we=%b addr=%h wdata=%h wmask=%h, expected req=%b addr=%h wmask=%h",
                     req, we, addr, wdata, wmask, !bad, w, wm);
        end
        if (!bad && a_opcode != 3'd4) ref_mem[w] = (ref_mem[w] & ~wm) | (a_data & wm);
        e.opcode = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
        e.source = a_source;
        e.size   = a_size;
        e.error  = bad;
        e.data   = (!bad && a_opcode == 3'd4) ? ref_mem[w] : 32'h0;
        exp_q.push_back(e);
        acc_cyc = cyc;
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [2:0] op, input logic [31:0] ad, input logic [1:0] sz,
                             input logic [3:0] m, input logic [31:0] dt);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = ad;
        a_size    = sz;
        a_mask    = m;
        a_data    = dt;
        a_source  = src_ctr;
        src_ctr   = src_ctr + 8'd1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                on_accept();
                @(posedge clk);
                #1;
                a_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got a_ready=0 for 50 cycles, expected accept");
        a_valid = 1'b0;
    endtask

    task automatic drain();
        checks++;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        errors++;
        $display("FAIL drain_timeout: got %0d responses pending, expected 0", exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        int acc;
        int first_acc;
        a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b1; a_opcode = Get; a_size = 2'd2; a_mask = 4'hf;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tl_o.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL a_ready_after_reset: got %b, expected 1", tl_o.a_ready);
        end
        @(posedge clk);
        #1;

        // write then read back
        send_beat(PutFullData, 32'h10, 2'd2, 4'hf, 32'hdeadbeef);
        send_beat(Get, 32'h10, 2'd2, 4'hf, 32'h0);
        drain();

        // partial write of byte 1
        send_beat(PutFullData, 32'h20, 2'd2, 4'hf, 32'h11223344);
        send_beat(PutPartialData, 32'h20, 2'd2, 4'b0010, 32'h0000ab00);
        send_beat(Get, 32'h20, 2'd2, 4'hf, 32'h0);
        drain();

        // error beats
        send_beat(3'd3, 32'h30, 2'd2, 4'hf, 32'h0);
        send_beat(Get, 32'h02, 2'd2, 4'hf, 32'h0);
        send_beat(Get, 32'h0001_0000, 2'd2, 4'hf, 32'h0);
        send_beat(PutFullData, 32'h40, 2'd1, 4'hf, 32'h12345678);
        drain();

        // backpressure: exactly Depth accepts with d_ready low
        dr_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        acc = 0;
        a_valid = 1'b1; a_opcode = Get; a_size = 2'd2; a_mask = 4'hf; a_address = 32'h10;
        a_source = src_ctr;
        for (int i = 0; i < int'(Depth) + 3; i++) begin
            @(negedge clk);
            if (tl_o.a_ready) begin
                on_accept();
                acc++;
                src_ctr = src_ctr + 8'd1;
            end
            @(posedge clk);
            #1;
            a_source  = src_ctr;
            a_address = 32'h10 + 32'(4 * acc);
        end
        a_valid = 1'b0;
        checks++;
        if (acc != int'(Depth) || tl_o.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accepts: got %0d a_ready=%b, expected %0d a_ready=0",
                     acc, tl_o.a_ready, Depth);
        end
        dr_mode = 0;
        drain();

        // throughput: 16 back-to-back Gets
        repeat (2) @(posedge clk);
        #1;
        dv_arm = 1;
        first_acc = 0;
        for (int i = 0; i < 16; i++) begin
            send_beat(Get, 32'(4 * i), 2'd2, 4'hf, 32'h0);
            if (i == 0) first_acc = acc_cyc;
        end
        checks++;
        if (acc_cyc - first_acc != 15) begin
            errors++;
            $display("FAIL throughput: got 16 accepts over %0d cycles, expected 16",
                     acc_cyc - first_acc + 1);
        end
        checks++;
        if (first_dv_cyc - first_acc != 2) begin
            errors++;
            $display("FAIL first_d_valid_latency: got %0d, expected 2", first_dv_cyc - first_acc);
        end
        drain();

        // reset with two responses buffered
        dr_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_beat(Get, 32'h10, 2'd2, 4'hf, 32'h0);
        send_beat(Get, 32'h14, 2'd2, 4'hf, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dr_mode = 0;
        @(negedge clk);
        checks++;
        if (tl_o.a_ready !== 1'b1 || tl_o.d_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_state: got a_ready=%b d_valid=%b, expected 1 and 0",
                     tl_o.a_ready, tl_o.d_valid);
        end
        repeat (8) @(posedge clk);
        #1;

        // randomised traffic with random d_ready
        dr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            int          r;
            int          sz;
            int          off;
            logic [2:0]  op;
            logic [31:0] ad;
            logic [3:0]  m;
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? Get : (r < 6) ? PutFullData : (r < 8) ? PutPartialData :
                 (r == 8) ? 3'($urandom_range(0, 7)) : Get;
            sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) off = int'($urandom_range(0, 3));
            else if (sz == 0) off = int'($urandom_range(0, 3));
            else if (sz == 1) off = 2 * int'($urandom_range(0, 1));
            else off = 0;
            ad = 32'(4 * int'($urandom_range(0, 15)) + off);
            if ($urandom_range(0, 19) == 0) ad = ad | (32'd1 << $urandom_range(AW + 2, 31));
            if (op == PutFullData && sz <= 2 && $urandom_range(0, 9) != 0)
                m = 4'(((1 << (1 << sz)) - 1) << off);
            else if (op == Get) m = 4'hf;
            else m = 4'($urandom_range(0, 15));
            send_beat(op, ad, 2'(sz), m, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        dr_mode = 0;
        drain();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
